sample_readout: RTL and testbench

- Upstream feeder for the SPI slave's transmit path.
- After a capture completes, walks sample memory for a programmed number of samples and hands each 32-bit word to the transmitter via send/send_data/send_valid.
- Paces itself on the transmitter's busy flag.
- Sits between the sample RAM and the spi_slave send interface.

---
 rtl/sample_readout_if.sv | 32 +++
 rtl/sample_readout.sv | 149 ++++++++++++++
 tb/tb_sample_readout.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_readout_if.sv
// sample_readout_if: control, sample-memory and transmitter-side signals of the
// sample readout block. The master modport is the readout engine; the slave
// modport is everything around it (control logic, sample RAM, SPI transmitter).
interface sample_readout_if #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 14
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  read_count;
  logic [3:0]        group_en;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              send;
  logic [31:0]       send_data;
  logic [3:0]        send_valid;
  logic              active;
  logic              done;

  modport master (
    input  start, abort, base_addr, read_count, group_en, mem_rdata, busy,
    output mem_rd, mem_addr, send, send_data, send_valid, active, done
  );

  modport slave (
    output start, abort, base_addr, read_count, group_en, mem_rdata, busy,
    input  mem_rd, mem_addr, send, send_data, send_valid, active, done
  );
endinterface

// File: rtl/sample_readout.sv
// sample_readout: after a capture, walks sample memory from base_addr for
// read_count words and hands each word to the SPI transmitter, one read in
// flight at a time, pacing on the transmitter busy flag.
// Build option: define SAMPLE_READOUT_DESCEND_EN to walk memory downwards
// (newest sample first); by default the address increments.
module sample_readout #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 14
) (
  input logic             clock,
  input logic             extReset,
  sample_readout_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LATCH     = 3'd2,
    WAIT_IDLE = 3'd3,
    SEND      = 3'd4,
    WAIT_ACK  = 3'd5,
    WAIT_DONE = 3'd6,
    FINISH    = 3'd7
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_step;
  logic [CNT_W-1:0]  remaining;
  logic [3:0]        grp;
  logic [31:0]       word;
  logic              rd_strobe;
  logic              send_pulse;
  logic [31:0]       data_out;
  logic [3:0]        valid_out;
  logic              active_flag;
  logic              done_pulse;

  // Address walk direction; wraps naturally modulo 2^ADDR_W.
`ifdef SAMPLE_READOUT_DESCEND_EN
  assign addr_step = addr - {{(ADDR_W-1){1'b0}}, 1'b1};
`else
  assign addr_step = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  // Next-state logic; abort overrides every transition, including start.
  always_comb begin
    next_state = state;
    if (bus.abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if ((bus.read_count == {CNT_W{1'b0}}) || (bus.group_en == 4'd0)) begin
              next_state = FINISH;
            end else begin
              next_state = READ;
            end
          end else begin
            next_state = IDLE;
          end
        end
        READ:      next_state = LATCH;
        LATCH:     next_state = WAIT_IDLE;
        WAIT_IDLE: next_state = bus.busy ? WAIT_IDLE : SEND;
        SEND:      next_state = WAIT_ACK;
        WAIT_ACK:  next_state = bus.busy ? WAIT_DONE : WAIT_ACK;
        WAIT_DONE: begin
          if (bus.busy) begin
            next_state = WAIT_DONE;
          end else if (remaining != {CNT_W{1'b0}}) begin
            next_state = READ;
          end else begin
            next_state = FINISH;
          end
        end
        FINISH:    next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Working registers: job parameters latched on an accepted start, read
  // data captured the cycle after the strobe, address/count advanced per send.
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      addr      <= {ADDR_W{1'b0}};
      remaining <= {CNT_W{1'b0}};
      grp       <= 4'd0;
      word      <= 32'd0;
    end else if ((state == IDLE) && (next_state != IDLE)) begin
      addr      <= bus.base_addr;
      remaining <= bus.read_count;
      grp       <= bus.group_en;
    end else if (state == LATCH) begin
      word      <= bus.mem_rdata;
    end else if (state == SEND) begin
      remaining <= remaining - {{(CNT_W-1){1'b0}}, 1'b1};
      addr      <= addr_step;
    end else begin
      addr      <= addr;
    end
  end

  // Registered outputs decoded from the state being entered, so each is a
  // flop that is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      rd_strobe   <= 1'b0;
      send_pulse  <= 1'b0;
      data_out    <= 32'd0;
      valid_out   <= 4'd0;
      active_flag <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      rd_strobe   <= (next_state == READ);
      send_pulse  <= (next_state == SEND);
      active_flag <= (next_state != IDLE);
      done_pulse  <= (next_state == FINISH);
      if (next_state == SEND) begin
        data_out  <= word;
        valid_out <= grp;
      end else begin
        data_out  <= data_out;
        valid_out <= valid_out;
      end
    end
  end

  assign bus.mem_rd     = rd_strobe;
  assign bus.mem_addr   = addr;
  assign bus.send       = send_pulse;
  assign bus.send_data  = data_out;
  assign bus.send_valid = valid_out;
  assign bus.active     = active_flag;
  assign bus.done       = done_pulse;

endmodule

// File: tb/tb_sample_readout.sv
// tb_sample_readout: table-driven and randomized checks of sample_readout
// against a memory model, a busy-flag transmitter model and a reference
// model of the expected word/address sequence.
module tb_sample_readout;
  localparam int ADDR_W = 13;
  localparam int CNT_W  = 14;

  logic clock = 1'b0;
  logic extReset;

  sample_readout_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  sample_readout #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .extReset (extReset),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:8191];
  logic [31:0] sent_data [$];
  logic [3:0]  sent_valid [$];
  logic [12:0] rd_addr [$];
  int          done_cnt = 0;
  int          hold_err = 0;
  int          cyc = 0;
  int          busy_release_cyc = 0;
  int          ack_dly = 2;
  int          hold_len = 2;

  typedef struct {
    logic [12:0] base;
    int          cnt;
    logic [3:0]  grp;
    int          ack;
    int          hold;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Address of the i-th word of a readout starting at base.
  function automatic logic [12:0] model_addr(input logic [12:0] base, input int i);
    logic [12:0] step;
    step = 13'(i);
`ifdef SAMPLE_READOUT_DESCEND_EN
    return base - step;
`else
    return base + step;
`endif
  endfunction

  function automatic logic [63:0] out_vec();
    return {11'd0, bus.mem_rd, bus.mem_addr, bus.send, bus.send_data,
            bus.send_valid, bus.active, bus.done};
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Monitor plus transmitter model: records sends/reads/done, checks output
  // hold, and raises busy ack_dly cycles after each send for hold_len cycles.
  initial begin
    logic [35:0] last_out;
    int          ack_cnt;
    int          hold_cnt;
    last_out = 36'd0;
    ack_cnt  = 0;
    hold_cnt = 0;
    bus.busy = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (bus.send) begin
        sent_data.push_back(bus.send_data);
        sent_valid.push_back(bus.send_valid);
      end
      if (bus.mem_rd) rd_addr.push_back(bus.mem_addr);
      if (bus.done) done_cnt++;
      if (extReset) last_out = 36'd0;
      else if (bus.send) last_out = {bus.send_data, bus.send_valid};
      else if ({bus.send_data, bus.send_valid} != last_out) hold_err++;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) hold_cnt = hold_len;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
      end
      if (bus.send) ack_cnt = ack_dly;
      bus.busy = (cyc < busy_release_cyc) || (hold_cnt > 0);
    end
  end

  // Sample RAM model: data valid for exactly the cycle after the read strobe.
  initial begin
    logic        p_rd;
    logic [12:0] p_addr;
    bus.mem_rdata = 32'h0BAD0BAD;
    forever begin
      @(negedge clock);
      p_rd   = bus.mem_rd;
      p_addr = bus.mem_addr;
      @(posedge clock);
      #1;
      bus.mem_rdata = p_rd ? mem[p_addr] : 32'h0BAD0BAD;
    end
  end

  task automatic wait_sends(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (sent_data.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({name, " send wait"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (!bus.active) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({name, " idle wait"}, 64'(ok), 64'd1);
  endtask

  // One complete readout, compared word by word with the reference model.
  task automatic run(input string name, input logic [12:0] base, input int cnt,
                     input logic [3:0] grp, output int n_sent,
                     output logic [31:0] first, output logic [31:0] last,
                     output int n_done);
    int s0, r0, d0, exp_n, n_rd, lim;
    s0 = sent_data.size();
    r0 = rd_addr.size();
    d0 = done_cnt;
    bus.base_addr  = base;
    bus.read_count = 14'(cnt);
    bus.group_en   = grp;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle(name);
    exp_n  = (grp == 4'd0) ? 0 : cnt;
    n_sent = sent_data.size() - s0;
    n_rd   = rd_addr.size() - r0;
    n_done = done_cnt - d0;
    check({name, " sends"}, 64'(n_sent), 64'(exp_n));
    check({name, " reads"}, 64'(n_rd), 64'(exp_n));
    check({name, " done"}, 64'(n_done), 64'd1);
    lim = exp_n;
    if (n_sent < lim) lim = n_sent;
    if (n_rd < lim) lim = n_rd;
    for (int i = 0; i < lim; i++) begin
      check({name, " addr"}, 64'(rd_addr[r0+i]), 64'(model_addr(base, i)));
      check({name, " data"}, 64'(sent_data[s0+i]), 64'(mem[model_addr(base, i)]));
      check({name, " valid"}, 64'(sent_valid[s0+i]), 64'(grp));
    end
    first = (n_sent > 0) ? sent_data[s0] : 32'd0;
    last  = (n_sent > 0) ? sent_data[s0+n_sent-1] : 32'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] l_basic, l_wrap, l_part, l_low, first, last;
    int n_sent, n_done, s0, r0, d0, c0;

`ifdef SAMPLE_READOUT_DESCEND_EN
    l_basic = 32'hA500000E; l_wrap = 32'hA5001FFB; l_part = 32'hA5000004; l_low = 32'hA5001FFF;
`else
    l_basic = 32'hA5000012; l_wrap = 32'hA5000001; l_part = 32'hA5000006; l_low = 32'hA5000003;
`endif
    vecs[0] = '{13'h0010, 3, 4'hF, 2, 2, 3, 32'hA5000010, l_basic, 1};
    vecs[1] = '{13'h1FFE, 4, 4'hF, 1, 1, 4, 32'hA5001FFE, l_wrap, 1};
    vecs[2] = '{13'h0100, 0, 4'hF, 2, 2, 0, 32'd0, 32'd0, 1};
    vecs[3] = '{13'h0100, 5, 4'h0, 2, 2, 0, 32'd0, 32'd0, 1};
    vecs[4] = '{13'h0005, 2, 4'h3, 3, 1, 2, 32'hA5000005, l_part, 1};
    vecs[5] = '{13'h0001, 3, 4'hA, 1, 3, 3, 32'hA5000001, l_low, 1};

    for (int n = 0; n < 8192; n++) mem[n] = 32'hA5000000 + 32'(n);
    extReset       = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.base_addr  = 13'd0;
    bus.read_count = 14'd0;
    bus.group_en   = 4'd0;
    #12;
    check("reset outputs", out_vec(), 64'd0);
    @(negedge clock);
    extReset = 1'b0;
    tick();
    tick();
    check("idle after reset", out_vec(), 64'd0);

    // Table-driven readouts.
    for (int i = 0; i < 6; i++) begin
      ack_dly  = vecs[i].ack;
      hold_len = vecs[i].hold;
      run($sformatf("vec%0d", i), vecs[i].base, vecs[i].cnt, vecs[i].grp,
          n_sent, first, last, n_done);
      check($sformatf("vec%0d count", i), 64'(n_sent), 64'(vecs[i].exp_n));
      check($sformatf("vec%0d first", i), 64'(first), 64'(vecs[i].exp_first));
      check($sformatf("vec%0d last", i), 64'(last), 64'(vecs[i].exp_last));
      check($sformatf("vec%0d done", i), 64'(n_done), 64'(vecs[i].exp_done));
    end

    // Start-to-first-send latency with the transmitter idle.
    ack_dly = 2; hold_len = 2;
    s0 = sent_data.size(); d0 = done_cnt; c0 = cyc;
    bus.base_addr = 13'h0030; bus.read_count = 14'd1; bus.group_en = 4'hF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("active rise", 64'(bus.active), 64'd1);
    wait_sends(s0 + 1, "latency");
    check("first send latency", 64'(cyc - c0), 64'd4);
    wait_idle("latency");
    check("latency done", 64'(done_cnt - d0), 64'd1);

    // Zero-length job: done on the cycle after the start edge, nothing read.
    r0 = rd_addr.size();
    bus.base_addr = 13'h0000; bus.read_count = 14'd0; bus.group_en = 4'hF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero done pulse", 64'(bus.done), 64'd1);
    tick();
    check("zero done end", 64'({bus.done, bus.active}), 64'd0);
    check("zero no reads", 64'(rd_addr.size() - r0), 64'd0);

    // Backpressure: busy high 20 cycles; first send the cycle after it falls.
    s0 = sent_data.size(); d0 = done_cnt; c0 = cyc;
    busy_release_cyc = c0 + 21;
    bus.base_addr = 13'h0020; bus.read_count = 14'd2; bus.group_en = 4'hF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_sends(s0 + 1, "backpressure");
    check("backpressure send cycle", 64'(cyc), 64'(busy_release_cyc + 1));
    wait_idle("backpressure");
    check("backpressure sends", 64'(sent_data.size() - s0), 64'd2);
    check("backpressure done", 64'(done_cnt - d0), 64'd1);

    // Abort in WAIT_DONE after word 2 of 5, with an ignored start mid-job.
    ack_dly = 2; hold_len = 3;
    s0 = sent_data.size(); r0 = rd_addr.size(); d0 = done_cnt;
    bus.base_addr = 13'h0040; bus.read_count = 14'd5; bus.group_en = 4'hF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_sends(s0 + 1, "abort w1");
    bus.base_addr = 13'h0300; bus.read_count = 14'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_sends(s0 + 2, "abort w2");
    tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort active", 64'(bus.active), 64'd0);
    for (int t = 0; t < 30; t++) tick();
    check("abort sends", 64'(sent_data.size() - s0), 64'd2);
    check("abort reads", 64'(rd_addr.size() - r0), 64'd2);
    check("abort no done", 64'(done_cnt - d0), 64'd0);
    if (sent_data.size() >= s0 + 2) begin
      check("abort word1", 64'(sent_data[s0+1]), 64'(mem[model_addr(13'h0040, 1)]));
    end else begin
      check("abort word1 present", 64'(sent_data.size()), 64'(s0 + 2));
    end

    // Asynchronous reset while waiting for the transmitter to accept.
    ack_dly = 3; hold_len = 2;
    s0 = sent_data.size();
    bus.base_addr = 13'h0050; bus.read_count = 14'd3; bus.group_en = 4'hF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_sends(s0 + 1, "reset");
    tick();
    #2;
    extReset = 1'b1;
    #1;
    check("async reset outputs", out_vec(), 64'd0);
    @(negedge clock);
    extReset = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    ack_dly = 2; hold_len = 2;
    run("after reset", 13'h0700, 2, 4'h5, n_sent, first, last, n_done);

    // Randomized jobs over random memory contents.
    for (int n = 0; n < 8192; n++) mem[n] = $urandom;
    for (int i = 0; i < 12; i++) begin
      ack_dly  = $urandom_range(1, 3);
      hold_len = $urandom_range(1, 3);
      run($sformatf("rand%0d", i), 13'($urandom), $urandom_range(0, 6),
          4'($urandom_range(0, 15)), n_sent, first, last, n_done);
    end

    check("send output hold", 64'(hold_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
